// File: rtl/game_timer.sv
// game_timer: scoreboard period clock (MM:SS) and shot clock (SS), BCD countdown driven by a synchronised slow tick.
module game_timer #(
    parameter int PERIOD_MIN    = 10,
    parameter int SHOT_SEC      = 24,
    parameter int NUM_PERIODS   = 4,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       tick_src,
    input  logic       start_pause,
    input  logic       shot_reset,
    input  logic       next_period,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [3:0] shot_tens,
    output logic [3:0] shot_units,
    output logic [2:0] period,
    output logic       running,
    output logic       buzzer,
    output logic       shot_expired,
    output logic       game_over
);
    localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [3:0] PM_T = 4'(PERIOD_MIN / 10);
    localparam logic [3:0] PM_U = 4'(PERIOD_MIN % 10);
    localparam logic [3:0] SH_T = 4'(SHOT_SEC / 10);
    localparam logic [3:0] SH_U = 4'(SHOT_SEC % 10);

    typedef enum logic [2:0] {IDLE, RUNNING, PAUSED, PERIOD_END, GAME_END} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync_q, sync_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    min_tens_q, min_units_q, sec_tens_q, sec_units_q;
    logic [3:0]    min_tens_d, min_units_d, sec_tens_d, sec_units_d;
    logic [3:0]    shot_tens_q, shot_units_q, shot_tens_d, shot_units_d;
    logic [2:0]    period_q, period_d;
    logic          running_q, running_d, buzzer_q, buzzer_d;
    logic          shot_expired_q, shot_expired_d, game_over_q, game_over_d;
    logic          tick, sec_strobe, shot_load, b0, b1, b2;
    logic          game_zero, game_last, shot_zero, shot_last;
    logic [3:0]    dmt, dmu, dst, dsu, dsht, dshu;

    assign tick       = sync_q[1] & ~sync_q[2];
    assign sec_strobe = tick && state_q == RUNNING && pre_q == PW'(TICKS_PER_SEC - 1);
    assign shot_load  = shot_reset && (state_q == IDLE || state_q == RUNNING || state_q == PAUSED);

    // Borrow chain for one-second decrement; a zero clock holds at zero.
    always_comb begin
        b0        = sec_units_q == 4'd0;
        b1        = b0 && sec_tens_q == 4'd0;
        b2        = b1 && min_units_q == 4'd0;
        game_zero = b2 && min_tens_q == 4'd0;
        game_last = game_zero || ({min_tens_q, min_units_q, sec_tens_q} == 12'd0 && sec_units_q == 4'd1);
        dsu       = game_zero ? 4'd0 : b0 ? 4'd9 : sec_units_q - 4'd1;
        dst       = game_zero ? 4'd0 : b0 ? (sec_tens_q == 4'd0 ? 4'd5 : sec_tens_q - 4'd1) : sec_tens_q;
        dmu       = game_zero ? 4'd0 : b1 ? (min_units_q == 4'd0 ? 4'd9 : min_units_q - 4'd1) : min_units_q;
        dmt       = game_zero ? 4'd0 : b2 ? min_tens_q - 4'd1 : min_tens_q;
        shot_zero = shot_tens_q == 4'd0 && shot_units_q == 4'd0;
        shot_last = shot_tens_q == 4'd0 && shot_units_q <= 4'd1;
        dshu      = shot_zero ? 4'd0 : shot_units_q == 4'd0 ? 4'd9 : shot_units_q - 4'd1;
        dsht      = shot_zero ? 4'd0 : shot_units_q == 4'd0 ? shot_tens_q - 4'd1 : shot_tens_q;
    end

    always_comb begin
        sync_d         = {sync_q[1:0], tick_src};
        state_d        = state_q;
        pre_d          = pre_q;
        min_tens_d     = min_tens_q;
        min_units_d    = min_units_q;
        sec_tens_d     = sec_tens_q;
        sec_units_d    = sec_units_q;
        shot_tens_d    = shot_tens_q;
        shot_units_d   = shot_units_q;
        period_d       = period_q;
        buzzer_d       = 1'b0;
        shot_expired_d = 1'b0;
        case (state_q)
            IDLE: if (start_pause) state_d = RUNNING;
            RUNNING: begin
                if (tick) pre_d = sec_strobe ? '0 : pre_q + PW'(1);
                if (sec_strobe) begin
                    {min_tens_d, min_units_d, sec_tens_d, sec_units_d} = {dmt, dmu, dst, dsu};
                    {shot_tens_d, shot_units_d} = {dsht, dshu};
                    if (game_last) begin
                        state_d  = PERIOD_END;
                        buzzer_d = 1'b1;
                    end else if (shot_last && !shot_reset) begin
                        state_d        = PAUSED;
                        shot_expired_d = 1'b1;
                    end else if (start_pause) state_d = PAUSED;
                end else if (start_pause) state_d = PAUSED;
            end
            PAUSED: if (start_pause && (!shot_zero || shot_reset)) state_d = RUNNING;
            PERIOD_END: if (next_period) begin
                if (period_q < 3'(NUM_PERIODS)) begin
                    period_d = period_q + 3'd1;
                    {min_tens_d, min_units_d, sec_tens_d, sec_units_d} = {PM_T, PM_U, 8'h00};
                    {shot_tens_d, shot_units_d} = {SH_T, SH_U};
                    pre_d   = '0;
                    state_d = IDLE;
                end else state_d = GAME_END;
            end
            default: ;
        endcase
        if (shot_load) {shot_tens_d, shot_units_d} = {SH_T, SH_U};
        running_d   = state_d == RUNNING;
        game_over_d = state_d == GAME_END;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sync_q         <= '0;
            pre_q          <= '0;
            {min_tens_q, min_units_q, sec_tens_q, sec_units_q} <= {PM_T, PM_U, 8'h00};
            {shot_tens_q, shot_units_q} <= {SH_T, SH_U};
            period_q       <= 3'd1;
            running_q      <= 1'b0;
            buzzer_q       <= 1'b0;
            shot_expired_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            pre_q          <= pre_d;
            {min_tens_q, min_units_q, sec_tens_q, sec_units_q} <= {min_tens_d, min_units_d, sec_tens_d, sec_units_d};
            {shot_tens_q, shot_units_q} <= {shot_tens_d, shot_units_d};
            period_q       <= period_d;
            running_q      <= running_d;
            buzzer_q       <= buzzer_d;
            shot_expired_q <= shot_expired_d;
            game_over_q    <= game_over_d;
        end
    end

    assign {min_tens, min_units, sec_tens, sec_units} = {min_tens_q, min_units_q, sec_tens_q, sec_units_q};
    assign {shot_tens, shot_units} = {shot_tens_q, shot_units_q};
    assign period       = period_q;
    assign running      = running_q;
    assign buzzer       = buzzer_q;
    assign shot_expired = shot_expired_q;
    assign game_over    = game_over_q;
endmodule
